// File: rtl/o_sync_lock.sv
// Scope sync lock detector: measures HS line period and lines per VS frame, then walks IDLE/SEARCH/VERIFY/LOCKED.
// Optional lock-loss statistics counter is built only when O_SYNC_LOCK_STATS_EN is defined.
module o_sync_lock #(
   parameter int   H_TOTAL     = 800,
   parameter int   H_TOL       = 4,
   parameter int   V_TOTAL     = 417,
   parameter int   LOCK_FRAMES = 4,
   parameter logic HS_POL      = 1'b0,
   parameter logic VS_POL      = 1'b0
) (
   input  logic        O_CLK,
   input  logic        O_RST_N,
   input  logic        SYNC_EN,
   input  logic        O_HS,
   input  logic        O_VS,
   output logic        ENABLE,
   output logic [1:0]  STATE,
   output logic [10:0] LINE_LEN,
   output logic [9:0]  FRAME_LINES,
   output logic        LOSS,
   output logic [7:0]  LOSS_COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   localparam logic [10:0] LEN_MIN   = 11'(H_TOTAL - H_TOL);
   localparam logic [10:0] LEN_MAX   = 11'(H_TOTAL + H_TOL);
   localparam logic [10:0] LINE_SAT  = 11'd2047;
   localparam logic [9:0]  FRAME_SAT = 10'd1023;
   localparam logic [9:0]  V_LINES   = 10'(V_TOTAL);
   localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

   logic        hs_prev_q, vs_prev_q;
   logic [10:0] line_cnt_q, line_cnt_d;
   logic [10:0] line_len_q, line_len_d;
   logic [9:0]  frame_cnt_q, frame_cnt_d;
   logic [9:0]  frame_lines_q, frame_lines_d;
   logic        bad_q, bad_d;
   logic [3:0]  good_cnt_q, good_cnt_d;
   state_t      state_q, state_d;
   logic        enable_q, enable_d;
   logic        loss_q, loss_d;

   logic        hs_edge, vs_edge;
   logic [11:0] line_next;
   logic [10:0] line_meas;
   logic        line_bad, timeout, frame_good;

   always_comb begin
      hs_edge    = (O_HS == HS_POL) && (hs_prev_q != HS_POL);
      vs_edge    = (O_VS == VS_POL) && (vs_prev_q != VS_POL);
      line_next  = {1'b0, line_cnt_q} + 12'd1;
      line_meas  = line_next[11] ? LINE_SAT : line_next[10:0];
      line_bad   = (line_meas < LEN_MIN) || (line_meas > LEN_MAX);
      timeout    = (line_cnt_q == LINE_SAT);
      frame_good = (frame_cnt_q == V_LINES) && !bad_q;
   end

   // A coincident HS edge opens the new frame, so its count and its line verdict go to the next frame.
   always_comb begin
      line_cnt_d    = hs_edge ? 11'd0 : (timeout ? line_cnt_q : line_cnt_q + 11'd1);
      line_len_d    = hs_edge ? line_meas : line_len_q;
      frame_cnt_d   = frame_cnt_q;
      frame_lines_d = frame_lines_q;
      bad_d         = bad_q;
      if (vs_edge) begin
         frame_lines_d = frame_cnt_q;
         frame_cnt_d   = hs_edge ? 10'd1 : 10'd0;
         bad_d         = hs_edge && line_bad;
      end else if (hs_edge) begin
         frame_cnt_d   = (frame_cnt_q == FRAME_SAT) ? frame_cnt_q : frame_cnt_q + 10'd1;
         bad_d         = bad_q || line_bad;
      end
   end

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      loss_d     = 1'b0;
      if (!SYNC_EN) begin
         state_d    = ST_IDLE;
         good_cnt_d = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SEARCH;
            ST_SEARCH: begin
               if (vs_edge) begin
                  state_d    = ST_VERIFY;
                  good_cnt_d = 4'd0;
               end
            end
            ST_VERIFY: begin
               if (timeout) begin
                  state_d = ST_SEARCH;
               end else if (vs_edge) begin
                  if (frame_good) begin
                     good_cnt_d = good_cnt_q + 4'd1;
                     if (good_cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
                  end else begin
                     good_cnt_d = 4'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (timeout || (vs_edge && !frame_good)) begin
                  state_d = ST_SEARCH;
                  loss_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      enable_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge O_CLK or negedge O_RST_N) begin
      if (!O_RST_N) begin
         hs_prev_q     <= ~HS_POL;
         vs_prev_q     <= ~VS_POL;
         line_cnt_q    <= 11'd0;
         line_len_q    <= 11'd0;
         frame_cnt_q   <= 10'd0;
         frame_lines_q <= 10'd0;
         bad_q         <= 1'b0;
         good_cnt_q    <= 4'd0;
         state_q       <= ST_IDLE;
         enable_q      <= 1'b0;
         loss_q        <= 1'b0;
      end else begin
         hs_prev_q     <= O_HS;
         vs_prev_q     <= O_VS;
         line_cnt_q    <= line_cnt_d;
         line_len_q    <= line_len_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_lines_q <= frame_lines_d;
         bad_q         <= bad_d;
         good_cnt_q    <= good_cnt_d;
         state_q       <= state_d;
         enable_q      <= enable_d;
         loss_q        <= loss_d;
      end
   end

`ifdef O_SYNC_LOCK_STATS_EN
   logic [7:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = (loss_d && (loss_cnt_q != 8'hFF)) ? loss_cnt_q + 8'd1 : loss_cnt_q;
   end

   always_ff @(posedge O_CLK or negedge O_RST_N) begin
      if (!O_RST_N) loss_cnt_q <= 8'd0;
      else          loss_cnt_q <= loss_cnt_d;
   end

   assign LOSS_COUNT = loss_cnt_q;
`else
   assign LOSS_COUNT = 8'd0;
`endif

   assign ENABLE      = enable_q;
   assign STATE       = state_q;
   assign LINE_LEN    = line_len_q;
   assign FRAME_LINES = frame_lines_q;
   assign LOSS        = loss_q;

endmodule

// File: tb/tb_o_sync_lock.sv
// Scoreboard bench for o_sync_lock: a line/frame-level model predicts each VS-edge and lock-loss outcome,
// a monitor compares them as the DUT produces them.
module tb_o_sync_lock;

   localparam int H_TOTAL     = 40;
   localparam int H_TOL       = 4;
   localparam int V_TOTAL     = 12;
   localparam int LOCK_FRAMES = 4;
   localparam int HS_W        = 4;
   localparam int VS_W        = 6;

   logic        O_CLK   = 1'b0;
   logic        O_RST_N = 1'b0;
   logic        SYNC_EN = 1'b0;
   logic        O_HS    = 1'b1;
   logic        O_VS    = 1'b1;
   logic        ENABLE;
   logic [1:0]  STATE;
   logic [10:0] LINE_LEN;
   logic [9:0]  FRAME_LINES;
   logic        LOSS;
   logic [7:0]  LOSS_COUNT;

   o_sync_lock #(
      .H_TOTAL(H_TOTAL), .H_TOL(H_TOL), .V_TOTAL(V_TOTAL),
      .LOCK_FRAMES(LOCK_FRAMES), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .O_CLK(O_CLK), .O_RST_N(O_RST_N), .SYNC_EN(SYNC_EN), .O_HS(O_HS), .O_VS(O_VS),
      .ENABLE(ENABLE), .STATE(STATE), .LINE_LEN(LINE_LEN), .FRAME_LINES(FRAME_LINES),
      .LOSS(LOSS), .LOSS_COUNT(LOSS_COUNT)
   );

   always #5 O_CLK = ~O_CLK;

   typedef struct {
      int state;
      int loss;
      int lossCnt;
      int frameLines;
      int lineLen;
   } rec_t;

   rec_t frameQ[$];
   rec_t lossQ[$];

   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   lastHsCyc  = 0;
   int   vsLeft     = 0;
   logic enVal      = 1'b0;

   // Reference model state, kept per frame/line rather than per cycle.
   int mState, mRun, mFrameCnt, mFrameLines, mLineLen, mLossCnt;
   bit mFrameBad;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      mState = 0; mRun = 0; mFrameCnt = 0; mFrameLines = 0;
      mLineLen = 0; mLossCnt = 0; mFrameBad = 1'b0;
   endfunction

   function automatic void modelLoss();
`ifdef O_SYNC_LOCK_STATS_EN
      if (mLossCnt < 255) mLossCnt++;
`endif
   endfunction

   function automatic rec_t snap(input int loss);
      rec_t r;
      r.state = mState; r.loss = loss; r.lossCnt = mLossCnt;
      r.frameLines = mFrameLines; r.lineLen = mLineLen;
      return r;
   endfunction

   function automatic int modelVs();
      int loss = 0;
      bit good;
      good        = (mFrameCnt == V_TOTAL) && !mFrameBad;
      mFrameLines = mFrameCnt;
      mFrameCnt   = 0;
      mFrameBad   = 1'b0;
      if (mState == 1) begin
         mState = 2; mRun = 0;
      end else if (mState == 2) begin
         if (good) begin
            mRun++;
            if (mRun >= LOCK_FRAMES) mState = 3;
         end else begin
            mRun = 0;
         end
      end else if (mState == 3 && !good) begin
         mState = 1; loss = 1; modelLoss();
      end
      return loss;
   endfunction

   function automatic void modelHs(input int meas);
      mLineLen = meas;
      if (meas < H_TOTAL - H_TOL || meas > H_TOTAL + H_TOL) mFrameBad = 1'b1;
      if (mFrameCnt < 1023) mFrameCnt++;
   endfunction

   function automatic void modelTimeout();
      if (mState == 2) begin
         mState = 1;
      end else if (mState == 3) begin
         mState = 1; modelLoss();
         lossQ.push_back(snap(1));
      end
   endfunction

   task automatic stepCycle(input logic hs, input logic vs);
      @(posedge O_CLK);
      #1;
      O_HS = hs; O_VS = vs; SYNC_EN = enVal;
      cyc++;
   endtask

   // One line starts with an HS edge; vsOff places a VS edge inside it (-1 for none).
   task automatic driveLine(input int len, input int vsOff);
      int   meas;
      int   lossV;
      logic vs;
      for (int i = 0; i < len; i++) begin
         if (i == vsOff) vsLeft = VS_W;
         vs = (vsLeft > 0) ? 1'b0 : 1'b1;
         if (vsLeft > 0) vsLeft--;
         stepCycle((i < HS_W) ? 1'b0 : 1'b1, vs);
         lossV = 0;
         if (i == vsOff) lossV = modelVs();
         if (i == 0) begin
            meas = cyc - lastHsCyc;
            if (meas > 2047) meas = 2047;
            lastHsCyc = cyc;
            modelHs(meas);
         end
         if (i == vsOff) frameQ.push_back(snap(lossV));
         if (i == 1 && len > 2100) modelTimeout();
      end
   endtask

   function automatic int randLen();
      int r = $urandom_range(0, 99);
      if (r < 85) return H_TOTAL - H_TOL + $urandom_range(0, 2 * H_TOL);
      if (r < 92) return H_TOTAL - H_TOL - $urandom_range(1, 5);
      return H_TOTAL + H_TOL + $urandom_range(1, 5);
   endfunction

   // mode 0 nominal lines, 1 alternating tolerance limits, 2 fully randomised frames.
   task automatic applyStimulus(input int nFrames, input int nLines, input int mode,
                                input int vsOff, input int badAt, input int badLen);
      int nl, vo, len, r;
      for (int f = 0; f < nFrames; f++) begin
         nl = nLines; vo = vsOff;
         if (mode == 2) begin
            r  = $urandom_range(0, 99);
            nl = (r < 80) ? V_TOTAL : (($urandom_range(0, 1) == 1) ? V_TOTAL + 1 : V_TOTAL - 1);
            r  = $urandom_range(0, 4);
            vo = (r == 0) ? 0 : ((r == 1) ? 20 : 10);
         end
         for (int l = 0; l < nl; l++) begin
            if (mode == 1)      len = (l % 2 == 1) ? H_TOTAL + H_TOL : H_TOTAL - H_TOL;
            else if (mode == 2) len = randLen();
            else                len = H_TOTAL;
            if (l == badAt) len = badLen;
            driveLine(len, (l == 0) ? vo : -1);
         end
      end
   endtask

   task automatic driveUntilLocked(input int maxFrames, input int mode);
      for (int f = 0; f < maxFrames; f++) begin
         if (mState == 3) break;
         applyStimulus(1, V_TOTAL, mode, 10, -1, 0);
      end
      checkOutput("lockReached", int'(STATE), 3);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "State"},      int'(STATE), 0);
      checkOutput({tag, "Enable"},     int'(ENABLE), 0);
      checkOutput({tag, "Loss"},       int'(LOSS), 0);
      checkOutput({tag, "LineLen"},    int'(LINE_LEN), 0);
      checkOutput({tag, "FrameLines"}, int'(FRAME_LINES), 0);
      checkOutput({tag, "LossCount"},  int'(LOSS_COUNT), 0);
   endtask

   // Monitor: pops a frame record on every VS edge the DUT samples, a loss record on any other LOSS pulse.
   initial begin
      logic prevVs, vsNow, vsEdge;
      rec_t r;
      prevVs = 1'b1;
      forever begin
         @(posedge O_CLK);
         vsNow  = O_VS;
         vsEdge = O_RST_N && !vsNow && prevVs;
         prevVs = O_RST_N ? vsNow : 1'b1;
         #2;
         if (vsEdge) begin
            if (frameQ.size() == 0) begin
               compared++; mismatched++;
               $display("[TB] FAIL frameQUnderflow: got VS edge, expected no record pending");
            end else begin
               r = frameQ.pop_front();
               checkOutput("vsState",      int'(STATE), r.state);
               checkOutput("vsEnable",     int'(ENABLE), (r.state == 3) ? 1 : 0);
               checkOutput("vsLoss",       int'(LOSS), r.loss);
               checkOutput("vsFrameLines", int'(FRAME_LINES), r.frameLines);
               checkOutput("vsLineLen",    int'(LINE_LEN), r.lineLen);
               checkOutput("vsLossCount",  int'(LOSS_COUNT), r.lossCnt);
            end
         end else if (LOSS) begin
            if (lossQ.size() == 0) begin
               checkOutput("spuriousLoss", int'(LOSS), 0);
            end else begin
               r = lossQ.pop_front();
               checkOutput("lossState",     int'(STATE), r.state);
               checkOutput("lossEnable",    int'(ENABLE), 0);
               checkOutput("lossLineLen",   int'(LINE_LEN), r.lineLen);
               checkOutput("lossLossCount", int'(LOSS_COUNT), r.lossCnt);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      repeat (3) @(posedge O_CLK);
      #1;
      checkResetValues("reset");
      @(posedge O_CLK); #1;
      O_RST_N = 1'b1; cyc++; lastHsCyc = cyc - 1;

      enVal = 1'b1;
      stepCycle(1'b1, 1'b1);
      mState = 1;
      stepCycle(1'b1, 1'b1);
      checkOutput("searchState", int'(STATE), 1);

      repeat (3) driveLine(H_TOTAL, -1);
      applyStimulus(5, V_TOTAL, 0, 10, -1, 0);
      checkOutput("nominalState",      int'(STATE), 3);
      checkOutput("nominalEnable",     int'(ENABLE), 1);
      checkOutput("nominalLineLen",    int'(LINE_LEN), H_TOTAL);
      checkOutput("nominalFrameLines", int'(FRAME_LINES), V_TOTAL);

      applyStimulus(1, V_TOTAL, 0, 10, 5, H_TOTAL + 10);
      applyStimulus(1, V_TOTAL, 0, 10, -1, 0);
      checkOutput("longLineState", int'(STATE), 1);
`ifdef O_SYNC_LOCK_STATS_EN
      checkOutput("longLineLossCount", int'(LOSS_COUNT), 1);
`else
      checkOutput("longLineLossCount", int'(LOSS_COUNT), 0);
`endif

      applyStimulus(2, V_TOTAL, 1, 10, -1, 0);
      applyStimulus(1, V_TOTAL, 1, 10, 3, H_TOTAL - H_TOL - 1);
      applyStimulus(1, V_TOTAL, 1, 10, -1, 0);
      checkOutput("verifyAfterBad", int'(STATE), 2);
      driveUntilLocked(8, 1);

      applyStimulus(1, V_TOTAL - 1, 0, 10, -1, 0);
      applyStimulus(1, V_TOTAL, 0, 10, -1, 0);
      checkOutput("shortFrameState", int'(STATE), 1);
      checkOutput("shortFrameLines", int'(FRAME_LINES), V_TOTAL - 1);

      applyStimulus(6, V_TOTAL, 0, 0, -1, 0);
      checkOutput("coincFrameLines", int'(FRAME_LINES), V_TOTAL);
      checkOutput("coincState",      int'(STATE), 3);

      applyStimulus(25, V_TOTAL, 2, 10, -1, 0);

      driveUntilLocked(10, 0);
      driveLine(2200, -1);
      driveLine(H_TOTAL, -1);
      checkOutput("postTimeoutState",   int'(STATE), 1);
      checkOutput("postTimeoutLineLen", int'(LINE_LEN), 2047);

      driveUntilLocked(10, 0);
      enVal = 1'b0;
      stepCycle(1'b1, 1'b1);
      mState = 0; mRun = 0;
      stepCycle(1'b1, 1'b1);
      checkOutput("dropState",  int'(STATE), 0);
      checkOutput("dropEnable", int'(ENABLE), 0);
      checkOutput("dropLoss",   int'(LOSS), 0);
      enVal = 1'b1;
      stepCycle(1'b1, 1'b1);
      mState = 1;
      stepCycle(1'b1, 1'b1);
      checkOutput("reenableState", int'(STATE), 1);

      driveUntilLocked(10, 0);
      #3;
      O_RST_N = 1'b0;
      #1;
      checkResetValues("midLockReset");
      repeat (2) @(posedge O_CLK);
      @(posedge O_CLK); #1;
      O_RST_N = 1'b1; cyc++; lastHsCyc = cyc - 1;
      modelReset();
      mState = 1;
      driveUntilLocked(10, 0);

      repeat (5) stepCycle(1'b1, 1'b1);
      checkOutput("frameQDrained", frameQ.size(), 0);
      checkOutput("lossQDrained",  lossQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
